xor_fold_unit: RTL and testbench

XOR_FOLD_UNIT -- requirements
Module: xor_fold_unit

---
 rtl/xor_fold_unit.sv | 163 ++++++++++++++++
 tb/tb_xor_fold_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/xor_fold_unit.sv
// xor_fold_unit: single-beat XOR/XNOR operations and multi-beat XOR folding
// behind a ready/valid handshake. Results are registered together with their
// even parity and the number of beats that contributed to them.
module xor_fold_unit #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [1:0]       OP,
    input  logic             IN_LAST,
    input  logic [WIDTH-1:0] IN0,
    input  logic [WIDTH-1:0] IN1,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT0,
    output logic             OUT_PAR,
    output logic [CNTW-1:0]  OUT_CNT
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FOLD = 1'b1
    } state_t;

    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};
    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    // Even parity of a data word (XOR reduction).
    function automatic logic parity_of(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    // Beat counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
        logic [CNTW-1:0] r;
        if (c == CNT_MAX) begin
            r = c;
        end else begin
            r = c + CNT_ONE;
        end
        return r;
    endfunction

    state_t           state_r;
    logic [WIDTH-1:0] acc_r;
    logic [CNTW-1:0]  cnt_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out0_r;
    logic             out_par_r;
    logic [CNTW-1:0]  out_cnt_r;

    logic             accept_s;
    logic             produce_s;
    logic [WIDTH-1:0] result_s;
    logic [CNTW-1:0]  res_cnt_s;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] acc_nxt_s;
    logic [CNTW-1:0]  cnt_nxt_s;

    // The output register can take a new result whenever it is empty or being drained.
    assign IN_READY  = !out_valid_r | OUT_READY;
    assign accept_s  = IN_VALID & IN_READY;

    assign OUT_VALID = out_valid_r;
    assign OUT0      = out0_r;
    assign OUT_PAR   = out_par_r;
    assign OUT_CNT   = out_cnt_r;

    // Decode the accepted beat into a result and the next fold state.
    always_comb begin
        produce_s   = 1'b0;
        result_s    = {WIDTH{1'b0}};
        res_cnt_s   = {CNTW{1'b0}};
        state_nxt_s = state_r;
        acc_nxt_s   = acc_r;
        cnt_nxt_s   = cnt_r;
        if (accept_s) begin
            case (state_r)
                ST_IDLE: begin
                    case (OP)
                        2'b01: begin
                            produce_s = 1'b1;
                            result_s  = ~(IN0 ^ IN1);
                            res_cnt_s = CNT_ONE;
                        end
                        2'b10: begin
                            if (IN_LAST) begin
                                produce_s = 1'b1;
                                result_s  = IN0;
                                res_cnt_s = CNT_ONE;
                            end else begin
                                acc_nxt_s   = IN0;
                                cnt_nxt_s   = CNT_ONE;
                                state_nxt_s = ST_FOLD;
                            end
                        end
                        // XOR, and the reserved code which aliases to XOR.
                        default: begin
                            produce_s = 1'b1;
                            result_s  = IN0 ^ IN1;
                            res_cnt_s = CNT_ONE;
                        end
                    endcase
                end
                ST_FOLD: begin
                    // OP is ignored inside a packet; every beat is fold data.
                    if (IN_LAST) begin
                        produce_s   = 1'b1;
                        result_s    = acc_r ^ IN0;
                        res_cnt_s   = sat_inc(cnt_r);
                        acc_nxt_s   = {WIDTH{1'b0}};
                        cnt_nxt_s   = {CNTW{1'b0}};
                        state_nxt_s = ST_IDLE;
                    end else begin
                        acc_nxt_s = acc_r ^ IN0;
                        cnt_nxt_s = sat_inc(cnt_r);
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else begin
            produce_s = 1'b0;
        end
    end

    // Fold state: accumulator, beat count and packet phase; reset drops a partial packet.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
            acc_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CNTW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            acc_r   <= acc_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Output register: load on a new result, clear after a transfer, otherwise hold.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid_r <= 1'b0;
            out0_r      <= {WIDTH{1'b0}};
            out_par_r   <= 1'b0;
            out_cnt_r   <= {CNTW{1'b0}};
        end else if (produce_s) begin
            out_valid_r <= 1'b1;
            out0_r      <= result_s;
            out_par_r   <= parity_of(result_s);
            out_cnt_r   <= res_cnt_s;
        end else if (OUT_READY) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

endmodule

// File: tb/tb_xor_fold_unit.sv
// Self-checking bench for xor_fold_unit: a vector table feeds a scoreboard
// that is checked as results leave the unit, plus hand-written sequences for
// back-pressure, reset in the middle of a packet and counter saturation.
module tb_xor_fold_unit;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] op;
    logic       in_last;
    logic [7:0] in0;
    logic [7:0] in1;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out0;
    logic       out_par;
    logic [7:0] out_cnt;

    logic       b_valid;
    logic       b_ready;
    logic [1:0] b_op;
    logic       b_last;
    logic [7:0] b_in0;
    logic [7:0] b_in1;
    logic       b_out_valid;
    logic [7:0] b_out0;
    logic       b_out_par;
    logic [1:0] b_out_cnt;

    xor_fold_unit #(.WIDTH(8), .CNTW(8)) dut (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
        .OP(op), .IN_LAST(in_last), .IN0(in0), .IN1(in1),
        .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .OUT0(out0), .OUT_PAR(out_par), .OUT_CNT(out_cnt)
    );

    xor_fold_unit #(.WIDTH(8), .CNTW(2)) dut_sat (
        .CLK(clk), .RST(rst), .IN_VALID(b_valid), .IN_READY(b_ready),
        .OP(b_op), .IN_LAST(b_last), .IN0(b_in0), .IN1(b_in1),
        .OUT_VALID(b_out_valid), .OUT_READY(1'b1),
        .OUT0(b_out0), .OUT_PAR(b_out_par), .OUT_CNT(b_out_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       last;
        logic       prod;
        logic [7:0] e0;
        logic       ep;
        logic [7:0] ecnt;
    } vec_t;

    typedef struct {
        logic [7:0] o;
        logic       p;
        logic [7:0] c;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[16];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one beat, wait (bounded) for acceptance, and record its expected result.
    task automatic send(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic l, input logic prod, input logic [7:0] e0,
                        input logic ep, input logic [7:0] ec);
        int waited;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1; op = o; in0 = a; in1 = b; in_last = l;
        #4;
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            #4;
            waited++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'(in_ready), 64'd1);
        end else if (prod) begin
            e.o = e0; e.p = ep; e.c = ec;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait (bounded) until all expected results have left and the output is empty.
    task automatic wait_drain(input string name);
        for (int k = 0; k < 100; k++) begin
            if (sb.size() == 0 && !out_valid) break;
            @(negedge clk);
            #4;
        end
        check({name, "_queue"}, 64'(sb.size()), 64'd0);
        check({name, "_valid"}, 64'(out_valid), 64'd0);
    endtask

    // Scoreboard monitor: compare every completed output transfer.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 64'(out0), 64'hDEAD);
                end else begin
                    e = sb.pop_front();
                    check("out0", 64'(out0), 64'(e.o));
                    check("out_par", 64'(out_par), 64'(e.p));
                    check("out_cnt", 64'(out_cnt), 64'(e.c));
                end
            end
        end
    end

    initial begin
        vecs[0]  = '{2'b00, 8'hA5, 8'h0F, 1'b0, 1'b1, 8'hAA, 1'b0, 8'd1};
        vecs[1]  = '{2'b01, 8'hFF, 8'h0F, 1'b0, 1'b1, 8'h0F, 1'b0, 8'd1};
        vecs[2]  = '{2'b11, 8'h12, 8'h34, 1'b0, 1'b1, 8'h26, 1'b1, 8'd1};
        vecs[3]  = '{2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 8'd1};
        vecs[4]  = '{2'b01, 8'h00, 8'h01, 1'b0, 1'b1, 8'hFE, 1'b1, 8'd1};
        vecs[5]  = '{2'b10, 8'h80, 8'hFF, 1'b1, 1'b1, 8'h80, 1'b1, 8'd1};
        vecs[6]  = '{2'b00, 8'hFF, 8'h01, 1'b0, 1'b1, 8'hFE, 1'b1, 8'd1};
        vecs[7]  = '{2'b10, 8'h01, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0};
        vecs[8]  = '{2'b00, 8'h02, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0};
        vecs[9]  = '{2'b01, 8'h04, 8'hFF, 1'b1, 1'b1, 8'h07, 1'b1, 8'd3};
        vecs[10] = '{2'b10, 8'h11, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0};
        vecs[11] = '{2'b10, 8'h22, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0};
        vecs[12] = '{2'b11, 8'h44, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0};
        vecs[13] = '{2'b10, 8'h88, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 8'd4};
        vecs[14] = '{2'b01, 8'h0F, 8'h0F, 1'b1, 1'b1, 8'hFF, 1'b0, 8'd1};
        vecs[15] = '{2'b11, 8'hF0, 8'h0F, 1'b0, 1'b1, 8'hFF, 1'b0, 8'd1};

        rst = 1'b1; in_valid = 1'b0; op = 2'b00; in_last = 1'b0;
        in0 = 8'h00; in1 = 8'h00; out_ready = 1'b1;
        b_valid = 1'b0; b_op = 2'b10; b_last = 1'b0; b_in0 = 8'h00; b_in1 = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        #4;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out0", 64'(out0), 64'd0);
        check("rst_out_par", 64'(out_par), 64'd0);
        check("rst_out_cnt", 64'(out_cnt), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        #4;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Table-driven vectors, back to back
        for (int i = 0; i < 16; i++) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].last, vecs[i].prod,
                 vecs[i].e0, vecs[i].ep, vecs[i].ecnt);
        end
        wait_drain("table");

        // Back-pressure: result 0x3C held for three cycles
        @(negedge clk);
        out_ready = 1'b0;
        send(2'b00, 8'h3C, 8'h00, 1'b0, 1'b1, 8'h3C, 1'b0, 8'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #4;
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_out0", 64'(out0), 64'h3C);
            check("stall_cnt", 64'(out_cnt), 64'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1; op = 2'b00; in0 = 8'h55; in1 = 8'h00; in_last = 1'b0;
        sb.push_back('{8'h55, 1'b0, 8'd1});
        #4;
        check("xfer_in_ready", 64'(in_ready), 64'd1);
        check("xfer_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_drain("stall");

        // Reset in the middle of a packet, with a colliding beat
        send(2'b10, 8'h11, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0);
        send(2'b10, 8'h22, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1; op = 2'b10; in_last = 1'b1; in0 = 8'hFF;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        #4;
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        check("rst_mid_in_ready", 64'(in_ready), 64'd1);
        send(2'b10, 8'h10, 8'h00, 1'b1, 1'b1, 8'h10, 1'b1, 8'd1);
        wait_drain("rst_mid");

        // Counter saturation with CNTW=2: five-beat packet reports 3
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            b_valid = 1'b1; b_op = 2'b10; b_in0 = 8'h01 << i; b_in1 = 8'hAA;
            b_last = (i == 4);
            #4;
            check("sat_in_ready", 64'(b_ready), 64'd1);
            check("sat_no_early", 64'(b_out_valid), 64'd0);
            @(posedge clk);
            #1;
            b_valid = 1'b0;
        end
        @(negedge clk);
        #4;
        check("sat_valid", 64'(b_out_valid), 64'd1);
        check("sat_out0", 64'(b_out0), 64'h1F);
        check("sat_par", 64'(b_out_par), 64'd1);
        check("sat_cnt", 64'(b_out_cnt), 64'd3);

        wait_drain("final");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
